// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encodings and
// control-word bit positions used between the controller and the datapath.
// No logic; types and constants only.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Control-word bit positions (load / shift / clear per register)
    localparam int CW_MCAND_LD = 0;  // MCAND <= A
    localparam int CW_ACC_CLR  = 1;  // ACC   <= 0
    localparam int CW_ACC_ADD  = 2;  // add MCAND into this iteration's sum
    localparam int CW_ACC_SHR  = 3;  // ACC   <= sum[nBit:1]
    localparam int CW_MQ_LD    = 4;  // MQ    <= B
    localparam int CW_MQ_SHR   = 5;  // MQ    <= {sum[0], MQ[nBit-1:1]}
    localparam int CW_CTR_CLR  = 6;  // CTR   <= 0
    localparam int CW_CTR_SHL  = 7;  // CTR   <= {CTR[nBit-2:0], 1'b1}
    localparam int CW_C_CLR    = 8;  // C     <= 0
    localparam int CW_W        = 9;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/shift_add_multiplier_datapath.sv
// Purpose: multiplier registers (MCAND, ACC, MQ, C, CTR) and the nBit+1 adder.
// Ports: clk/clr, ctrl_word from the controller, operands a/b; returns mq_lsb,
//        ctr_msb, ctr_msb_next to the controller and the product p = {ACC, MQ}.
module shift_add_multiplier_datapath
    import shift_add_multiplier_pkg::*;
#(
    parameter int nBit = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  ctrl_word_t        ctrl_word,
    input  logic [nBit-1:0]   a,
    input  logic [nBit-1:0]   b,
    output logic              mq_lsb,
    output logic              ctr_msb,
    output logic              ctr_msb_next,
    output logic [2*nBit-1:0] p
);

    logic [nBit-1:0] mcand;
    logic [nBit-1:0] acc;
    logic [nBit-1:0] mq;
    logic [nBit-1:0] ctr;
    logic            c;
    logic [nBit:0]   addend;
    logic [nBit:0]   sum;

    // C is always zero entering an iteration, so {C,ACC} is ACC zero-extended.
    always_comb begin
        addend = '0;
        if (ctrl_word[CW_ACC_ADD]) addend = {1'b0, mcand};
        sum = {c, acc} + addend;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mcand <= '0;
            acc   <= '0;
            mq    <= '0;
            ctr   <= '0;
            c     <= 1'b0;
        end else begin
            if (ctrl_word[CW_MCAND_LD]) mcand <= a;

            if (ctrl_word[CW_ACC_CLR])      acc <= '0;
            else if (ctrl_word[CW_ACC_SHR]) acc <= sum[nBit:1];

            // Sum LSB drops into MQ's top as the multiplier bits shift out.
            if (ctrl_word[CW_MQ_LD])       mq <= b;
            else if (ctrl_word[CW_MQ_SHR]) mq <= {sum[0], mq[nBit-1:1]};

            if (ctrl_word[CW_CTR_CLR])      ctr <= '0;
            else if (ctrl_word[CW_CTR_SHL]) ctr <= {ctr[nBit-2:0], 1'b1};

            if (ctrl_word[CW_C_CLR]) c <= 1'b0;
        end
    end

    assign mq_lsb       = mq[0];
    assign ctr_msb      = ctr[nBit-1];
    assign ctr_msb_next = ctr[nBit-2];
    assign p            = {acc, mq};

endmodule

// File: rtl/shift_add_multiplier.sv
// Purpose: sequential unsigned nBit x nBit shift-add multiplier, start/done handshake.
// Ports: clk, clr (sync active-high), start, A, B in; busy, done, P (2*nBit) out.
// Latency nBit+2 cycles accept-to-done; start is ignored outside IDLE.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int nBit = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [nBit-1:0]   A,
    input  logic [nBit-1:0]   B,
    output logic              busy,
    output logic              done,
    output logic [2*nBit-1:0] P
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t ctrl_word;
    logic       mq_lsb;
    logic       ctr_msb;
    logic       ctr_msb_next;

    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ctrl_word = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ctrl_word[CW_MCAND_LD] = 1'b1;
                    ctrl_word[CW_MQ_LD]    = 1'b1;
                    ctrl_word[CW_ACC_CLR]  = 1'b1;
                    ctrl_word[CW_C_CLR]    = 1'b1;
                    ctrl_word[CW_CTR_CLR]  = 1'b1;
                    state_d                = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy                   = 1'b1;
                ctrl_word[CW_ACC_ADD]  = mq_lsb;
                ctrl_word[CW_ACC_SHR]  = 1'b1;
                ctrl_word[CW_MQ_SHR]   = 1'b1;
                ctrl_word[CW_CTR_SHL]  = 1'b1;
                ctrl_word[CW_C_CLR]    = 1'b1;
                // This edge's shift fills CTR[nBit-1]: it is the nBit-th
                // iteration. A counter that is already full never re-triggers.
                if (ctr_msb_next && !ctr_msb) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    shift_add_multiplier_datapath #(.nBit(nBit)) u_datapath (
        .clk          (clk),
        .clr          (clr),
        .ctrl_word    (ctrl_word),
        .a            (A),
        .b            (B),
        .mq_lsb       (mq_lsb),
        .ctr_msb      (ctr_msb),
        .ctr_msb_next (ctr_msb_next),
        .p            (P)
    );

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: nBit=8 instance driven through a scoreboard
// (expected product and accept cycle queued at issue, checked by a monitor on
// done), plus an nBit=4 instance checked inline for the ignored re-start case.
module tb_shift_add_multiplier;

    localparam int N8 = 8;
    localparam int N4 = 4;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic              start = 1'b0;
    logic [N8-1:0]     a_in = '0;
    logic [N8-1:0]     b_in = '0;
    logic              busy;
    logic              done;
    logic [2*N8-1:0]   p;

    logic              clr4 = 1'b1;
    logic              start4 = 1'b0;
    logic [N4-1:0]     a4 = '0;
    logic [N4-1:0]     b4 = '0;
    logic              busy4;
    logic              done4;
    logic [2*N4-1:0]   p4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit hold_mode = 1'b0;
    int hold_dones = 0;
    int last_done = 0;

    logic [2*N8-1:0] exp_q[$];
    int              acc_q[$];

    shift_add_multiplier #(.nBit(N8)) dut (
        .clk(clk), .clr(clr), .start(start), .A(a_in), .B(b_in),
        .busy(busy), .done(done), .P(p)
    );

    shift_add_multiplier #(.nBit(N4)) dut4 (
        .clk(clk), .clr(clr4), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .P(p4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1, 0);
    endtask

    // Issue one request; the accept edge is the tick inside, so cyc == k after it.
    task automatic issue(input logic [N8-1:0] a, input logic [N8-1:0] b, input bit expect_done);
        wait_idle();
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        a_in  = 8'hAA;  // operands are don't-care after accept
        b_in  = 8'h55;
        if (expect_done) begin
            exp_q.push_back({8'd0, a} * {8'd0, b});
            acc_q.push_back(cyc);
        end
    endtask

    // Monitor: every done must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                chk("busy_with_done", busy, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    logic [2*N8-1:0] e;
                    int              k;
                    e = exp_q.pop_front();
                    k = acc_q.pop_front();
                    chk("product", p, e);
                    // Accept at edge k; done visible in the cycle after edge k+nBit+1.
                    if (k >= 0) chk("latency", cyc - k, N8 + 1);
                end
                if (hold_mode) begin
                    // Accept, nBit+1 edges to DONE, 1 to IDLE, 1 to re-accept.
                    if (hold_dones > 0) chk("b2b_period", cyc - last_done, N8 + 3);
                    hold_dones++;
                end
                last_done = cyc;
            end
        end
    end

    initial begin
        // Reset
        clr  = 1'b1;
        clr4 = 1'b1;
        tick();
        tick();
        chk("reset_p", p, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_p4", p4, 0);
        clr  = 1'b0;
        clr4 = 1'b0;
        tick();

        // Directed products (143, 65025 exercises carry into ACC[7], zero, identity)
        issue(8'd13,  8'd11,  1'b1);
        issue(8'd255, 8'd255, 1'b1);
        issue(8'd0,   8'd200, 1'b1);
        issue(8'd200, 8'd1,   1'b1);
        wait_idle();
        tick();
        chk("p_holds_in_idle", p, 200);

        // Back-to-back: start held high, three operations 3*5
        begin
            int n = 0;
            hold_mode = 1'b1;
            repeat (3) begin
                exp_q.push_back(16'd15);
                acc_q.push_back(-1);
            end
            start = 1'b1;
            a_in  = 8'd3;
            b_in  = 8'd5;
            while (hold_dones < 3 && n < 200) begin
                tick();
                n++;
            end
            start = 1'b0;
            hold_mode = 1'b0;
            if (n >= 200) chk("b2b_timeout", 1, 0);
            chk("b2b_count", hold_dones, 3);
        end
        wait_idle();
        tick();

        // Abort: clr sampled at the end of the 4th RUN cycle
        issue(8'd37, 8'd91, 1'b0);
        repeat (4) tick();
        chk("abort_busy_before", busy, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_p", p, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (15) tick();  // any done here is flagged by the monitor
        issue(8'd37, 8'd91, 1'b1);

        // Start re-pulsed mid-RUN is ignored
        issue(8'd100, 8'd3, 1'b1);
        repeat (3) tick();
        start = 1'b1;
        a_in  = 8'd2;
        b_in  = 8'd2;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (15) tick();
        chk("restart_ignored_p", p, 300);

        // nBit=4: 15*15 with a re-pulse mid-RUN
        begin
            int k;
            int n = 0;
            start4 = 1'b1;
            a4 = 4'd15;
            b4 = 4'd15;
            tick();
            k = cyc;
            start4 = 1'b0;
            a4 = 4'd0;
            b4 = 4'd0;
            tick();
            tick();
            start4 = 1'b1;
            a4 = 4'd2;
            b4 = 4'd2;
            tick();
            start4 = 1'b0;
            while (n < 50) begin
                @(negedge clk);
                if (done4) break;
                n++;
            end
            if (n >= 50) chk("n4_timeout", 1, 0);
            chk("n4_product", p4, 8'hE1);
            chk("n4_latency", cyc - k, N4 + 1);
            chk("n4_busy_with_done", busy4, 0);
            repeat (12) tick();
            chk("n4_p_held", p4, 8'hE1);
            chk("n4_idle_busy", busy4, 0);
        end

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
